bip_control: RTL

- Sequential instruction-fetch/decode controller for the accumulator datapath.
- Produces the operand-select, add/sub opcode and write strobes consumed by the datapath adder/subtractor, accumulator and data memory.
- Owns the program counter and drives the instruction-memory address.
- Reports halt status and a cycle count to the debug unit.

---
 rtl/bip_pkg.sv | 26 ++
 rtl/bip_decoder.sv | 70 +++++++
 rtl/bip_control.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcodes, state encodings and operand-select codes for the BIP controller
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'd0;
  localparam logic [4:0] OPC_STO  = 5'd1;
  localparam logic [4:0] OPC_LD   = 5'd2;
  localparam logic [4:0] OPC_LDI  = 5'd3;
  localparam logic [4:0] OPC_ADD  = 5'd4;
  localparam logic [4:0] OPC_ADDI = 5'd5;
  localparam logic [4:0] OPC_SUB  = 5'd6;
  localparam logic [4:0] OPC_SUBI = 5'd7;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - combinational opcode to datapath-control decode
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NBITS_OPC = 5
) (
  input  logic [NBITS_OPC-1:0] opc_i,
  output logic [1:0]           sel_a_o,
  output logic                 sel_b_o,
  output logic                 op_o,
  output logic                 rd_ram_o,
  output logic                 wr_ram_o,
  output logic                 wr_acc_o,
  output logic                 is_halt_o
);

  // Opcode table; undefined opcodes fall through to all-zero (NOP).
  always_comb begin
    sel_a_o   = SELA_MEM;
    sel_b_o   = 1'b0;
    op_o      = 1'b0;
    rd_ram_o  = 1'b0;
    wr_ram_o  = 1'b0;
    wr_acc_o  = 1'b0;
    is_halt_o = 1'b0;
    case (opc_i)
      OPC_HLT: begin
        is_halt_o = 1'b1;
      end
      OPC_STO: begin
        rd_ram_o = 1'b1;
        wr_ram_o = 1'b1;
      end
      OPC_LD: begin
        rd_ram_o = 1'b1;
        wr_acc_o = 1'b1;
        sel_a_o  = SELA_MEM;
      end
      OPC_LDI: begin
        wr_acc_o = 1'b1;
        sel_a_o  = SELA_IMM;
      end
      OPC_ADD: begin
        rd_ram_o = 1'b1;
        wr_acc_o = 1'b1;
        sel_a_o  = SELA_ALU;
      end
      OPC_ADDI: begin
        wr_acc_o = 1'b1;
        sel_a_o  = SELA_ALU;
        sel_b_o  = 1'b1;
      end
      OPC_SUB: begin
        rd_ram_o = 1'b1;
        wr_acc_o = 1'b1;
        sel_a_o  = SELA_ALU;
        op_o     = 1'b1;
      end
      OPC_SUBI: begin
        wr_acc_o = 1'b1;
        sel_a_o  = SELA_ALU;
        sel_b_o  = 1'b1;
        op_o     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// rtl/bip_control.sv - fetch/decode/execute FSM, program counter and cycle counter for the accumulator datapath
module bip_control
  import bip_pkg::*;
#(
  parameter int NBITS     = 16,
  parameter int NBITS_OPC = 5,
  parameter int NBITS_PC  = 11,
  parameter int NBITS_CYC = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_step_en,
  input  logic                 i_step,
  input  logic [NBITS-1:0]     i_Instr,
  output logic [NBITS_PC-1:0]  o_PC,
  output logic [NBITS_PC-1:0]  o_Operand,
  output logic [1:0]           o_SelA,
  output logic                 o_SelB,
  output logic                 o_Op,
  output logic                 o_RdRam,
  output logic                 o_WrRam,
  output logic                 o_WrAcc,
  output logic                 o_Halt,
  output logic [NBITS_CYC-1:0] o_Cycles
);

  state_e               state_q, state_d;
  logic [NBITS_PC-1:0]  pc_q, pc_d;
  logic [NBITS-1:0]     ir_q, ir_d;
  logic [NBITS_CYC-1:0] cyc_q, cyc_d;

  logic [NBITS_OPC-1:0] dec_opc;
  logic [1:0]           dec_sel_a;
  logic                 dec_sel_b;
  logic                 dec_op;
  logic                 dec_rd_ram;
  logic                 dec_wr_ram;
  logic                 dec_wr_acc;
  logic                 dec_is_halt;

  // One decoder serves both phases: the incoming instruction in DECODE
  // (for the early data-memory read) and the latched IR otherwise.
  always_comb begin
    dec_opc = ir_q[NBITS-1 -: NBITS_OPC];
    if (state_q == ST_DECODE) begin
      dec_opc = i_Instr[NBITS-1 -: NBITS_OPC];
    end
  end

  bip_decoder #(
    .NBITS_OPC (NBITS_OPC)
  ) u_decoder (
    .opc_i     (dec_opc),
    .sel_a_o   (dec_sel_a),
    .sel_b_o   (dec_sel_b),
    .op_o      (dec_op),
    .rd_ram_o  (dec_rd_ram),
    .wr_ram_o  (dec_wr_ram),
    .wr_acc_o  (dec_wr_acc),
    .is_halt_o (dec_is_halt)
  );

  // State, PC, IR and cycle-counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cyc_q   <= cyc_d;
    end
  end

  // Next-state, PC/IR update and strobe generation; strobes are masked
  // while reset is low so an interrupted EXEC cannot write anything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    o_Operand = ir_q[NBITS_PC-1:0];
    o_SelA    = SELA_MEM;
    o_SelB    = 1'b0;
    o_Op      = 1'b0;
    o_RdRam   = 1'b0;
    o_WrRam   = 1'b0;
    o_WrAcc   = 1'b0;
    o_Halt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d      = i_Instr;
        o_Operand = i_Instr[NBITS_PC-1:0];
        o_RdRam   = dec_rd_ram;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        o_SelA  = dec_sel_a;
        o_SelB  = dec_sel_b;
        o_Op    = dec_op;
        o_WrRam = dec_wr_ram;
        o_WrAcc = dec_wr_acc;
        if (dec_is_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + NBITS_PC'(1);
          state_d = i_step_en ? ST_WAIT : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (i_step || !i_step_en) begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        o_Halt = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!i_reset) begin
      o_SelA  = SELA_MEM;
      o_SelB  = 1'b0;
      o_Op    = 1'b0;
      o_RdRam = 1'b0;
      o_WrRam = 1'b0;
      o_WrAcc = 1'b0;
      o_Halt  = 1'b0;
    end
  end

  // Cycle counter runs in the active states and sticks at all-ones.
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == ST_FETCH) || (state_q == ST_DECODE) ||
        (state_q == ST_EXEC)  || (state_q == ST_WAIT)) begin
      if (cyc_q != {NBITS_CYC{1'b1}}) begin
        cyc_d = cyc_q + NBITS_CYC'(1);
      end
    end
  end

  assign o_PC     = pc_q;
  assign o_Cycles = cyc_q;

endmodule
